jstk_dir_scanner: RTL and testbench

JSTK_DIR_SCANNER -- requirements
Module: jstk_dir_scanner

---
 rtl/jstk_dir_scanner.sv | 187 ++++++++++++++++++
 tb/tb_jstk_dir_scanner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_dir_scanner.sv
// jstk_dir_scanner: round-robin SPI poller for N_CH joystick modules, decoding
// each 5-byte frame into X/Y position, buttons and a 4-way direction code.
module jstk_dir_scanner #(
    parameter int         N_CH      = 2,
    parameter int         SCLK_HALF = 25,
    parameter int         SETUP_CYC = 750,
    parameter int         GAP_CYC   = 500,
    parameter int         POLL_CYC  = 50000,
    parameter logic [9:0] CENTER    = 10'd512,
    parameter logic [9:0] DEADZONE  = 10'd96,
    parameter bit         HOLD_LAST = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_CH-1:0]     MISO,
    input  logic [2*N_CH-1:0]   LED,
    output logic                SCLK,
    output logic                MOSI,
    output logic [N_CH-1:0]     CS,
    output logic [4*N_CH-1:0]   direction,
    output logic [10*N_CH-1:0]  xpos,
    output logic [10*N_CH-1:0]  ypos,
    output logic [3*N_CH-1:0]   buttons,
    output logic                valid,
    output logic [1:0]          valid_ch
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    // SETUP is shortened by the first low half-bit so CS-fall to first SCLK rise is SETUP_CYC
    localparam int SETUP_T = (SETUP_CYC > SCLK_HALF) ? SETUP_CYC - SCLK_HALF : 1;
    localparam int MAX_AB  = (POLL_CYC > SETUP_T) ? POLL_CYC : SETUP_T;
    localparam int MAX_CD  = (GAP_CYC > SCLK_HALF) ? GAP_CYC : SCLK_HALF;
    localparam int MAXC    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAXC + 1);
    localparam logic [CW-1:0] POLL_END  = CW'(POLL_CYC - 1);
    localparam logic [CW-1:0] SETUP_END = CW'(SETUP_T - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(SCLK_HALF - 1);
    localparam logic [1:0]    LAST_CH   = 2'(N_CH - 1);

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [1:0]        ch;
    logic [2:0]        bitn;
    logic [2:0]        byt;
    logic              hi;
    logic [7:0]        tx;
    logic [7:0]        rx;
    logic [9:0]        x_cap;
    logic [9:0]        y_cap;
    logic [2:0]        b_cap;
    logic              miso_bit;
    logic [1:0]        led_sel;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [10:0]       adx;
    logic [10:0]       ady;
    logic              x_win;
    logic              y_win;
    logic              in_dz;
    logic [3:0]        dir_new;

    always_comb begin
        miso_bit = 1'b0;
        led_sel  = 2'b00;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == 2'(i)) begin
                miso_bit = MISO[i];
                led_sel  = LED[2*i +: 2];
            end
        end
    end

    // 11-bit signed offsets cover the full 0..1023 range, so the magnitudes never overflow
    assign dx      = $signed({1'b0, x_cap}) - $signed({1'b0, CENTER});
    assign dy      = $signed({1'b0, y_cap}) - $signed({1'b0, CENTER});
    assign adx     = dx[10] ? -dx : dx;
    assign ady     = dy[10] ? -dy : dy;
    assign x_win   = (adx >= ady) && (adx > {1'b0, DEADZONE});
    assign y_win   = ady > {1'b0, DEADZONE};
    assign in_dz   = !x_win && !y_win;
    assign dir_new = x_win ? (dx[10] ? 4'b0010 : 4'b0001) :
                     y_win ? (dy[10] ? 4'b0100 : 4'b1000) : 4'b0000;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            ch        <= '0;
            bitn      <= '0;
            byt       <= '0;
            hi        <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            x_cap     <= CENTER;
            y_cap     <= CENTER;
            b_cap     <= '0;
            CS        <= '1;
            SCLK      <= 1'b0;
            MOSI      <= 1'b0;
            valid     <= 1'b0;
            valid_ch  <= '0;
            direction <= '0;
            xpos      <= {N_CH{CENTER}};
            ypos      <= {N_CH{CENTER}};
            buttons   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cnt == POLL_END) begin
                        cnt   <= '0;
                        state <= SETUP;
                        for (int i = 0; i < N_CH; i++) CS[i] <= (ch != 2'(i));
                    end else cnt <= cnt + 1'b1;
                end
                SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt   <= '0;
                        state <= SHIFT;
                        tx    <= {6'b100000, led_sel};
                        MOSI  <= 1'b1;
                        bitn  <= '0;
                        byt   <= '0;
                        hi    <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
                SHIFT: begin
                    if (cnt != HALF_END) cnt <= cnt + 1'b1;
                    else begin
                        cnt  <= '0;
                        hi   <= !hi;
                        SCLK <= !hi;
                        if (!hi) rx <= {rx[6:0], miso_bit};
                        else if (bitn != 3'd7) begin
                            bitn <= bitn + 1'b1;
                            tx   <= {tx[6:0], 1'b0};
                            MOSI <= tx[6];
                        end else begin
                            bitn <= '0;
                            MOSI <= 1'b0;
                            case (byt)
                                3'd0:    x_cap[7:0] <= rx;
                                3'd1:    x_cap[9:8] <= rx[1:0];
                                3'd2:    y_cap[7:0] <= rx;
                                3'd3:    y_cap[9:8] <= rx[1:0];
                                default: b_cap      <= rx[2:0];
                            endcase
                            if (byt == 3'd4) begin
                                state <= DONE;
                                CS    <= '1;
                            end else begin
                                state <= GAP;
                                byt   <= byt + 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt   <= '0;
                        state <= SHIFT;
                        tx    <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    valid    <= 1'b1;
                    valid_ch <= ch;
                    ch       <= (ch == LAST_CH) ? 2'd0 : ch + 1'b1;
                    for (int i = 0; i < N_CH; i++) begin
                        if (ch == 2'(i)) begin
                            xpos[10*i +: 10]  <= x_cap;
                            ypos[10*i +: 10]  <= y_cap;
                            buttons[3*i +: 3] <= b_cap;
                            if (!HOLD_LAST || !in_dz) direction[4*i +: 4] <= dir_new;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jstk_dir_scanner.sv
// tb_jstk_dir_scanner: directed bench with SPI joystick slave models for a
// 3-channel holding scanner and a 1-channel non-holding scanner.
module tb_jstk_dir_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int nerr = 0;
    int nchk = 0;

    logic        rst_a, sclk_a, mosi_a, valid_a;
    logic [2:0]  miso_a = '0;
    logic [5:0]  led_a;
    logic [2:0]  cs_a;
    logic [11:0] dir_a;
    logic [29:0] xpos_a, ypos_a;
    logic [8:0]  btn_a;
    logic [1:0]  vch_a;

    logic        rst_b, sclk_b, mosi_b, valid_b;
    logic        miso_b = 1'b0;
    logic [1:0]  led_b;
    logic        cs_b;
    logic [3:0]  dir_b;
    logic [9:0]  xpos_b, ypos_b;
    logic [2:0]  btn_b;
    logic [1:0]  vch_b;

    jstk_dir_scanner #(.N_CH(3), .SCLK_HALF(2), .SETUP_CYC(6), .GAP_CYC(3), .POLL_CYC(10), .HOLD_LAST(1'b1)) dut_a (
        .CLK(clk), .RST(rst_a), .MISO(miso_a), .LED(led_a), .SCLK(sclk_a), .MOSI(mosi_a), .CS(cs_a),
        .direction(dir_a), .xpos(xpos_a), .ypos(ypos_a), .buttons(btn_a), .valid(valid_a), .valid_ch(vch_a));

    jstk_dir_scanner #(.N_CH(1), .SCLK_HALF(2), .SETUP_CYC(6), .GAP_CYC(3), .POLL_CYC(10), .HOLD_LAST(1'b0)) dut_b (
        .CLK(clk), .RST(rst_b), .MISO(miso_b), .LED(led_b), .SCLK(sclk_b), .MOSI(mosi_b), .CS(cs_b),
        .direction(dir_b), .xpos(xpos_b), .ypos(ypos_b), .buttons(btn_b), .valid(valid_b), .valid_ch(vch_b));

    // slave model A: frame latched when a CS falls, bits shifted out on SCLK falls
    logic [9:0]  xa[3], ya[3];
    logic [2:0]  ba[3];
    logic [39:0] fa = '0, ma = '0;
    int cha = 0, ia = 0, ra = 0, viol_cs = 0, viol_sck = 0;
    time ta_cs = 0;
    time tra[41];
    wire all_a = &cs_a;
    always @(negedge all_a) begin
        cha = !cs_a[0] ? 0 : !cs_a[1] ? 1 : 2;
        fa = {xa[cha][7:0], 6'b0, xa[cha][9:8], ya[cha][7:0], 6'b0, ya[cha][9:8], 5'b0, ba[cha]};
        ia = 39;
        ra = 0;
        ta_cs = $time;
        miso_a = '0;
        miso_a[cha] = fa[39];
    end
    always @(negedge sclk_a) if (!all_a && ia > 0) begin
        ia--;
        miso_a = '0;
        miso_a[cha] = fa[ia];
    end
    always @(posedge sclk_a) begin
        if (all_a) viol_sck++;
        else begin
            ma = {ma[38:0], mosi_a};
            if (ra < 41) tra[ra] = $time;
            ra++;
        end
    end
    always @(negedge clk) if ($countones(~cs_a) > 1) viol_cs++;

    logic [9:0]  xb, yb;
    logic [2:0]  bb;
    logic [39:0] fb = '0, mb = '0;
    int ib = 0, rb = 0;
    always @(negedge cs_b) begin
        fb = {xb[7:0], 6'b0, xb[9:8], yb[7:0], 6'b0, yb[9:8], 5'b0, bb};
        ib = 39;
        rb = 0;
        miso_b = fb[39];
    end
    always @(negedge sclk_b) if (!cs_b && ib > 0) begin
        ib--;
        miso_b = fb[ib];
    end
    always @(posedge sclk_b) if (!cs_b) begin
        mb = {mb[38:0], mosi_b};
        rb++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid_a();
        int n = 0;
        while (valid_a !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("valid_a_seen", 64'(valid_a), 64'd1);
    endtask

    task automatic wait_valid_b();
        int n = 0;
        while (valid_b !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("valid_b_seen", 64'(valid_b), 64'd1);
    endtask

    initial begin
        int n;
        rst_a = 1'b0;
        rst_b = 1'b0;
        led_a = 6'b00_11_10;
        led_b = 2'b01;
        xa[0] = 10'd1000; ya[0] = 10'd512; ba[0] = 3'd5;
        xa[1] = 10'd100;  ya[1] = 10'd900; ba[1] = 3'd2;
        xa[2] = 10'd512;  ya[2] = 10'd900; ba[2] = 3'd7;
        xb = 10'd1000; yb = 10'd512; bb = 3'd3;
        repeat (3) @(negedge clk);
        chk("rst_cs", 64'(cs_a), 64'h7);
        chk("rst_sclk", 64'(sclk_a), 64'd0);
        chk("rst_mosi", 64'(mosi_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_xpos", 64'(xpos_a), 64'({3{10'd512}}));
        chk("rst_dir", 64'(dir_a), 64'd0);
        chk("rst_btn", 64'(btn_a), 64'd0);
        rst_a = 1'b1;

        wait_valid_a();
        chk("f0_vch", 64'(vch_a), 64'd0);
        chk("f0_dir", 64'(dir_a), 64'h001);
        chk("f0_xpos", 64'(xpos_a), 64'({10'd512, 10'd512, 10'd1000}));
        chk("f0_ypos", 64'(ypos_a), 64'({3{10'd512}}));
        chk("f0_btn", 64'(btn_a), 64'o005);
        chk("f0_mosi", 64'(ma), 64'h82_0000_0000);
        chk("f0_rises", 64'(ra), 64'd40);
        chk("f0_setup", 64'(tra[0] - ta_cs), 64'd60);
        chk("f0_bitgap", 64'(tra[1] - tra[0]), 64'd40);
        chk("f0_bytegap", 64'(tra[8] - tra[7]), 64'd70);
        chk("f0_cs", 64'(cs_a), 64'h7);
        @(negedge clk);
        chk("f0_pulse", 64'(valid_a), 64'd0);
        xa[0] = 10'd608; ya[0] = 10'd416; ba[0] = 3'd0;

        wait_valid_a();
        chk("f1_vch", 64'(vch_a), 64'd1);
        chk("f1_dir", 64'(dir_a), 64'h021);
        chk("f1_xpos", 64'(xpos_a), 64'({10'd512, 10'd100, 10'd1000}));
        chk("f1_btn", 64'(btn_a), 64'o025);
        chk("f1_mosi", 64'(ma), 64'h83_0000_0000);
        @(negedge clk);

        wait_valid_a();
        chk("f2_vch", 64'(vch_a), 64'd2);
        chk("f2_dir", 64'(dir_a), 64'h821);
        chk("f2_ypos", 64'(ypos_a), 64'({10'd900, 10'd900, 10'd512}));
        chk("f2_btn", 64'(btn_a), 64'o725);
        chk("f2_mosi", 64'(ma), 64'h80_0000_0000);
        @(negedge clk);

        wait_valid_a();
        chk("f3_vch", 64'(vch_a), 64'd0);
        chk("f3_dir_hold", 64'(dir_a), 64'h821);
        chk("f3_xpos", 64'(xpos_a), 64'({10'd512, 10'd100, 10'd608}));
        chk("f3_ypos", 64'(ypos_a), 64'({10'd900, 10'd900, 10'd416}));
        chk("f3_btn", 64'(btn_a), 64'o720);
        @(negedge clk);

        n = 0;
        while (cs_a === 3'b111 && n < 500) begin @(negedge clk); n++; end
        chk("f4_cs_ch1", 64'(cs_a), 64'h5);
        n = 0;
        while (ra < 17 && n < 500) begin @(negedge clk); n++; end
        chk("f4_in_byte2", 64'(ra >= 17 && ra <= 24), 64'd1);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_cs", 64'(cs_a), 64'h7);
        chk("mid_rst_sclk", 64'(sclk_a), 64'd0);
        chk("mid_rst_valid", 64'(valid_a), 64'd0);
        chk("mid_rst_xpos", 64'(xpos_a), 64'({3{10'd512}}));
        chk("mid_rst_dir", 64'(dir_a), 64'd0);
        chk("mid_rst_btn", 64'(btn_a), 64'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        while (cs_a === 3'b111 && n < 500) begin @(negedge clk); n++; end
        chk("post_rst_cs_ch0", 64'(cs_a), 64'h6);
        wait_valid_a();
        chk("post_rst_vch", 64'(vch_a), 64'd0);
        chk("post_rst_dir", 64'(dir_a), 64'h000);
        chk("post_rst_xpos", 64'(xpos_a), 64'({10'd512, 10'd512, 10'd608}));
        chk("proto_a", 64'(viol_cs + viol_sck), 64'd0);

        rst_b = 1'b1;
        wait_valid_b();
        chk("b0_vch", 64'(vch_b), 64'd0);
        chk("b0_dir", 64'(dir_b), 64'h1);
        chk("b0_xpos", 64'(xpos_b), 64'd1000);
        chk("b0_btn", 64'(btn_b), 64'd3);
        chk("b0_mosi", 64'(mb), 64'h81_0000_0000);
        @(negedge clk);
        chk("b0_pulse", 64'(valid_b), 64'd0);
        xb = 10'd608; yb = 10'd416; bb = 3'd0;
        n = 0;
        while (cs_b !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        n = 0;
        while (rb < 2 && n < 500) begin @(negedge clk); n++; end
        led_b = 2'b10;
        wait_valid_b();
        chk("b1_dir_zero", 64'(dir_b), 64'h0);
        chk("b1_xpos", 64'(xpos_b), 64'd608);
        chk("b1_ypos", 64'(ypos_b), 64'd416);
        chk("b1_led_latched", 64'(mb), 64'h81_0000_0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
